// File: rtl/sha2_digest_bank.sv
// rtl/sha2_digest_bank.sv - multi-channel SHA-2 hash state bank with a single-entry digest output register
// Optional SHA-224 support is compiled in with SHA2_DIGEST_BANK_SHA224_EN.
module sha2_digest_bank #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic            clk,
    input  logic            RST,
    input  logic            init_valid_i,
    input  logic [CH_W-1:0] init_ch_i,
    input  logic            init_mode_i,
    input  logic            upd_valid_i,
    output logic            upd_ready_o,
    input  logic [CH_W-1:0] upd_ch_i,
    input  logic            upd_last_i,
    input  logic [255:0]    upd_work_i,
    output logic            dig_valid_o,
    input  logic            dig_ready_i,
    output logic [CH_W-1:0] dig_ch_o,
    output logic            dig_mode_o,
    output logic [255:0]    dig_out_o,
    output logic            err_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } ch_state_e;

    localparam logic [255:0] IV_256 =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    ch_state_e       st_q [NUM_CH];
    ch_state_e       st_d [NUM_CH];
    logic [255:0]    h_q  [NUM_CH];
    logic [255:0]    h_d  [NUM_CH];

    logic            dig_valid_q, dig_valid_d;
    logic [CH_W-1:0] dig_ch_q, dig_ch_d;
    logic            dig_mode_q, dig_mode_d;
    logic [255:0]    dig_out_q, dig_out_d;
    logic            err_q, err_d;

    logic [255:0]    iv_sel;
    logic [255:0]    sel_h;
    logic [255:0]    upd_sum;
    logic [255:0]    dig_word;
    logic            sel_active;
    logic            sel_mode;
    logic            upd_fire;
    logic            upd_take;

    // Eight independent 32-bit adds; carries stay inside each word.
    function automatic logic [255:0] add_words(input logic [255:0] a, input logic [255:0] b);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) begin
            r[32*i +: 32] = a[32*i +: 32] + b[32*i +: 32];
        end
        return r;
    endfunction

`ifdef SHA2_DIGEST_BANK_SHA224_EN
    localparam logic [255:0] IV_224 =
        256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;

    logic mode_q [NUM_CH];
    logic mode_d [NUM_CH];

    always_comb begin
        sel_mode = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            mode_d[c] = mode_q[c];
            if (init_valid_i && init_ch_i == CH_W'(c)) begin
                mode_d[c] = init_mode_i;
            end
            if (upd_ch_i == CH_W'(c)) begin
                sel_mode = mode_q[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            mode_q[c] <= RST ? 1'b0 : mode_d[c];
        end
    end

    assign iv_sel   = init_mode_i ? IV_224 : IV_256;
    // Only the emitted digest drops H7; the context keeps it for later blocks.
    assign dig_word = {upd_sum[255:32], sel_mode ? 32'h0 : upd_sum[31:0]};
`else
    logic unused_init_mode;
    assign unused_init_mode = init_mode_i;
    assign sel_mode         = 1'b0;
    assign iv_sel           = IV_256;
    assign dig_word         = upd_sum;
`endif

    assign upd_ready_o = !dig_valid_q || dig_ready_i;
    assign upd_fire    = upd_valid_i && upd_ready_o;
    // A same-cycle init on the update's channel wins and silently discards the update.
    assign upd_take    = upd_fire && !(init_valid_i && init_ch_i == upd_ch_i);
    assign upd_sum     = add_words(sel_h, upd_work_i);

    always_comb begin
        sel_h      = '0;
        sel_active = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (upd_ch_i == CH_W'(c)) begin
                sel_h      = h_q[c];
                sel_active = (st_q[c] == ST_ACTIVE);
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            st_d[c] = st_q[c];
            h_d[c]  = h_q[c];
            if (init_valid_i && init_ch_i == CH_W'(c)) begin
                st_d[c] = ST_ACTIVE;
                h_d[c]  = iv_sel;
            end else if (upd_take && sel_active && upd_ch_i == CH_W'(c)) begin
                h_d[c] = upd_sum;
                if (upd_last_i) begin
                    st_d[c] = ST_DONE;
                end
            end
        end
    end

    always_comb begin
        dig_valid_d = dig_valid_q;
        dig_ch_d    = dig_ch_q;
        dig_mode_d  = dig_mode_q;
        dig_out_d   = dig_out_q;
        err_d       = upd_take && !sel_active;
        if (upd_take && sel_active && upd_last_i) begin
            dig_valid_d = 1'b1;
            dig_ch_d    = upd_ch_i;
            dig_mode_d  = sel_mode;
            dig_out_d   = dig_word;
        end else if (dig_valid_q && dig_ready_i) begin
            dig_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            for (int c = 0; c < NUM_CH; c++) begin
                st_q[c] <= ST_IDLE;
                h_q[c]  <= IV_256;
            end
            dig_valid_q <= 1'b0;
            dig_ch_q    <= '0;
            dig_mode_q  <= 1'b0;
            dig_out_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                st_q[c] <= st_d[c];
                h_q[c]  <= h_d[c];
            end
            dig_valid_q <= dig_valid_d;
            dig_ch_q    <= dig_ch_d;
            dig_mode_q  <= dig_mode_d;
            dig_out_q   <= dig_out_d;
            err_q       <= err_d;
        end
    end

    assign dig_valid_o = dig_valid_q;
    assign dig_ch_o    = dig_ch_q;
    assign dig_mode_o  = dig_mode_q;
    assign dig_out_o   = dig_out_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_sha2_digest_bank.sv
// tb/tb_sha2_digest_bank.sv - directed and random checks of sha2_digest_bank against a word-level context model
module tb_sha2_digest_bank;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam int S_IDLE = 0, S_ACTIVE = 1, S_DONE = 2;

`ifdef SHA2_DIGEST_BANK_SHA224_EN
    localparam bit HAS224 = 1'b1;
`else
    localparam bit HAS224 = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            RST;
    logic            init_valid, init_mode, upd_valid, upd_last, dig_ready;
    logic [CH_W-1:0] init_ch, upd_ch;
    logic [255:0]    upd_work;
    logic            upd_ready_o, dig_valid_o, dig_mode_o, err_o;
    logic [CH_W-1:0] dig_ch_o;
    logic [255:0]    dig_out_o;

    always #5 clk = ~clk;

    sha2_digest_bank #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
        .clk(clk), .RST(RST),
        .init_valid_i(init_valid), .init_ch_i(init_ch), .init_mode_i(init_mode),
        .upd_valid_i(upd_valid), .upd_ready_o(upd_ready_o), .upd_ch_i(upd_ch),
        .upd_last_i(upd_last), .upd_work_i(upd_work),
        .dig_valid_o(dig_valid_o), .dig_ready_i(dig_ready), .dig_ch_o(dig_ch_o),
        .dig_mode_o(dig_mode_o), .dig_out_o(dig_out_o), .err_o(err_o)
    );

    int unsigned iv256 [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                               32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    int unsigned iv224 [8] = '{32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                               32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
    int unsigned abc   [8] = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                               32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};

    int unsigned     m_h  [NUM_CH][8];
    int              m_st [NUM_CH];
    bit              m_md [NUM_CH];
    bit              m_dv, m_err, m_mode;
    logic [CH_W-1:0] m_ch;
    logic [255:0]    m_out;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] pack(input int unsigned w [8]);
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[255-32*i -: 32] = w[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_st[c] = S_IDLE;
            m_md[c] = 1'b0;
            for (int i = 0; i < 8; i++) m_h[c][i] = iv256[i];
        end
        m_dv = 0; m_err = 0; m_mode = 0; m_ch = '0; m_out = '0;
    endtask

    task automatic idle_inputs();
        init_valid = 0; init_ch = '0; init_mode = 0;
        upd_valid = 0; upd_ch = '0; upd_last = 0; upd_work = '0;
    endtask

    task automatic upd(input int ch, input bit last, input logic [255:0] work);
        upd_valid = 1; upd_ch = CH_W'(ch); upd_last = last; upd_work = work;
    endtask

    task automatic init(input int ch, input bit mode);
        init_valid = 1; init_ch = CH_W'(ch); init_mode = mode;
    endtask

    // One clock: predict from the current inputs, advance, compare every output.
    task automatic cycle();
        bit rdy, fire, clash, newdig;
        int uc, ic;
        int unsigned s [8];
        #1;
        rdy = !m_dv || dig_ready;
        if (!RST) check("upd_ready", upd_ready_o, rdy);
        @(posedge clk);
        if (RST) begin
            model_reset();
        end else begin
            uc = int'(upd_ch); ic = int'(init_ch);
            fire   = upd_valid && rdy;
            clash  = init_valid && (ic == uc);
            newdig = 0;
            m_err  = 0;
            if (fire && !clash) begin
                if (m_st[uc] == S_ACTIVE) begin
                    for (int i = 0; i < 8; i++) begin
                        s[i] = m_h[uc][i] + upd_work[255-32*i -: 32];
                        m_h[uc][i] = s[i];
                    end
                    if (upd_last) begin
                        m_st[uc] = S_DONE;
                        newdig = 1;
                        m_dv = 1; m_ch = upd_ch; m_mode = m_md[uc];
                        m_out = pack(s);
                        if (m_md[uc]) m_out[31:0] = 32'h0;
                    end
                end else begin
                    m_err = 1;
                end
            end
            if (!newdig && m_dv && dig_ready) m_dv = 0;
            if (init_valid) begin
                m_st[ic] = S_ACTIVE;
                m_md[ic] = HAS224 && init_mode;
                for (int i = 0; i < 8; i++) m_h[ic][i] = m_md[ic] ? iv224[i] : iv256[i];
            end
        end
        #1;
        check("dig_valid", dig_valid_o, m_dv);
        check("dig_ch",    dig_ch_o,    m_ch);
        check("dig_mode",  dig_mode_o,  m_mode);
        check("dig_out",   dig_out_o,   m_out);
        check("err",       err_o,       m_err);
    endtask

    initial begin
        int unsigned w [8];
        logic [255:0] held, exp224;

        model_reset();
        idle_inputs();
        dig_ready = 1;
        RST = 1;
        cycle(); cycle();
        RST = 0;
        #1;
        check("rst_upd_ready", upd_ready_o, 1'b1);
        check("rst_dig_valid", dig_valid_o, 1'b0);
        check("rst_dig_out",   dig_out_o,   256'h0);
        check("rst_err",       err_o,       1'b0);

        // SHA-256 IV straight through
        init(0, 0); cycle(); idle_inputs();
        upd(0, 1, '0); cycle(); idle_inputs();
        check("iv_valid", dig_valid_o, 1'b1);
        check("iv_ch",    dig_ch_o, 2'd0);
        check("iv_out",   dig_out_o,
              256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19);
        cycle();

        // "abc" digest via work = abc - IV
        for (int i = 0; i < 8; i++) w[i] = abc[i] - iv256[i];
        init(1, 0); cycle(); idle_inputs();
        upd(1, 1, pack(w)); cycle(); idle_inputs();
        check("abc_out", dig_out_o,
              256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad);

        // Per-word wrap-around
        init(2, 0); cycle(); idle_inputs();
        upd(2, 1, {256{1'b1}}); cycle(); idle_inputs();
        check("wrap_h0", dig_out_o[255:224], 32'h6a09e666);
        check("wrap_h7", dig_out_o[31:0],    32'h5be0cd18);

        // SHA-224 mode request
        init(3, 1); cycle(); idle_inputs();
        upd(3, 1, '0); cycle(); idle_inputs();
        exp224 = HAS224 ?
            256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_00000000 :
            256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
        check("m224_out",  dig_out_o,  exp224);
        check("m224_mode", dig_mode_o, HAS224);
        cycle();

        // Backpressure with interleaved channels
        init(0, 0); cycle(); idle_inputs();
        init(1, 0); cycle(); idle_inputs();
        upd(0, 0, {8{$urandom}}); cycle();
        upd(1, 0, {8{$urandom}}); cycle();
        upd(0, 1, {8{$urandom}}); dig_ready = 0; cycle();
        upd(1, 1, {8{$urandom}});
        held = dig_out_o;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("bp_ready_low", upd_ready_o, 1'b0);
            check("bp_hold",      dig_out_o,   held);
            check("bp_ch0",       dig_ch_o,    2'd0);
        end
        dig_ready = 1; cycle(); idle_inputs();
        check("bp_second_valid", dig_valid_o, 1'b1);
        check("bp_second_ch",    dig_ch_o,    2'd1);
        cycle();

        // Dropped update and same-cycle init/update clash
        RST = 1; cycle(); RST = 0;
        upd(2, 1, '0); cycle(); idle_inputs();
        check("err_idle", err_o, 1'b1);
        init(0, 0); upd(0, 1, {8{$urandom}}); cycle(); idle_inputs();
        check("clash_err",   err_o,       1'b0);
        check("clash_valid", dig_valid_o, 1'b0);
        upd(0, 1, '0); cycle(); idle_inputs();
        check("clash_iv", dig_out_o,
              256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19);
        cycle();

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            idle_inputs();
            if ($urandom_range(0, 4) == 0) init(int'($urandom_range(0, NUM_CH-1)), bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 9) < 6)
                upd(int'($urandom_range(0, NUM_CH-1)), $urandom_range(0, 9) < 3,
                    {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
            dig_ready = ($urandom_range(0, 9) < 7);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
